vcve2_vlsu_agu: RTL and testbench

VCVE2_VLSU_AGU -- requirements
Module: vcve2_vlsu_agu

---
 rtl/vcve2_vlsu_pkg.sv | 30 +++
 rtl/vcve2_vlsu_addr_gen.sv | 39 +++
 rtl/vcve2_vlsu_agu.sv | 156 +++++++++++++++
 tb/tb_vcve2_vlsu_agu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcve2_vlsu_pkg.sv
// vcve2_vlsu_pkg: shared types and word-count/byte-enable helpers for the vector load/store AGU.
package vcve2_vlsu_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} vlsu_state_e;

    typedef enum logic [1:0] {
        SEW8    = 2'b00,
        SEW16   = 2'b01,
        SEW32   = 2'b10,
        SEW_ILL = 2'b11
    } sew_e;

    function automatic logic [7:0] calc_nwords(input logic [7:0] vl, input sew_e sew, input logic strided);
        logic [9:0] bytes;
        bytes = {2'b00, vl} << sew;
        calc_nwords = strided ? vl : 8'((bytes + 10'd3) >> 2);
    endfunction

    // Byte enable of the final unit-stride word: only the bytes that belong to the vector.
    function automatic logic [3:0] calc_last_be(input logic [7:0] vl, input sew_e sew);
        logic [9:0] bytes;
        bytes = {2'b00, vl} << sew;
        calc_last_be = (bytes[1:0] == 2'd0) ? 4'hF : 4'((5'd1 << bytes[1:0]) - 5'd1);
    endfunction

    function automatic logic [3:0] word_be(input logic [7:0] idx, input logic [7:0] nwords, input logic [3:0] last_be);
        word_be = (idx == nwords - 8'd1) ? last_be : 4'hF;
    endfunction

endpackage

// File: rtl/vcve2_vlsu_addr_gen.sv
// vcve2_vlsu_addr_gen: request counter plus address and byte-enable of the word being requested.
module vcve2_vlsu_addr_gen import vcve2_vlsu_pkg::*; (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        inc_i,
    input  logic [31:0] base_i,
    input  logic [31:0] stride_i,
    input  logic        strided_i,
    input  logic [7:0]  nwords_i,
    input  logic [3:0]  last_be_i,
    output logic [7:0]  req_cnt_o,
    output logic [31:0] addr_o,
    output logic [3:0]  be_o
);

    logic [7:0] req_cnt_q, req_cnt_d;

    always_comb req_cnt_d = clr_i ? 8'd0 : req_cnt_q + 8'(inc_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) req_cnt_q <= '0;
        else         req_cnt_q <= req_cnt_d;
    end

`ifdef VCVE2_VLSU_STRIDED_EN
    logic [31:0] stride_off;
    assign stride_off = stride_i * {24'd0, req_cnt_q};
    assign addr_o     = base_i + (strided_i ? stride_off : {22'd0, req_cnt_q, 2'b00});
`else
    logic unused_stride;
    assign unused_stride = ^{stride_i, strided_i};
    assign addr_o        = base_i + {22'd0, req_cnt_q, 2'b00};
`endif

    assign req_cnt_o = req_cnt_q;
    assign be_o      = word_be(req_cnt_q, nwords_i, last_be_i);

endmodule

// File: rtl/vcve2_vlsu_agu.sv
// vcve2_vlsu_agu: vector load/store AGU moving VRF words over one OBI lane.
// Define VCVE2_VLSU_STRIDED_EN to enable strided (32-bit element) accesses.
module vcve2_vlsu_agu import vcve2_vlsu_pkg::*; #(
    parameter int unsigned VrfAw          = 5,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             is_store_i,
    input  logic [31:0]      base_addr_i,
    input  logic [31:0]      stride_i,
    input  logic [7:0]       vl_i,
    input  logic [1:0]       sew_i,
    input  logic             strided_i,
    input  logic [VrfAw-1:0] vreg_base_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [VrfAw-1:0] vrf_raddr_o,
    input  logic [31:0]      vrf_rdata_i,
    output logic             vrf_we_o,
    output logic [VrfAw-1:0] vrf_waddr_o,
    output logic [31:0]      vrf_wdata_o,
    output logic [3:0]       vrf_wbe_o,
    output logic             data_req_o,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [31:0]      data_addr_o,
    output logic [31:0]      data_wdata_o,
    input  logic             data_gnt_i,
    input  logic             data_rvalid_i,
    input  logic [31:0]      data_rdata_i,
    input  logic             data_err_i
);

    vlsu_state_e      state_q, state_d;
    logic             is_store_q, is_store_d, strided_q, strided_d, err_q, err_d;
    logic [31:0]      base_q, base_d, stride_q, stride_d;
    logic [7:0]       nwords_q, nwords_d, resp_cnt_q, resp_cnt_d;
    logic [3:0]       last_be_q, last_be_d;
    logic [VrfAw-1:0] vreg_q, vreg_d;
    logic [1:0]       outst_q, outst_d;

    logic [31:0] cmd_stride, addr;
    logic        cmd_strided, cmd_illegal, start, req, rsp, vrf_write;
    logic [7:0]  req_cnt;
    logic [3:0]  be;

`ifdef VCVE2_VLSU_STRIDED_EN
    assign cmd_strided = strided_i;
    assign cmd_stride  = stride_i;
`else
    logic unused_cmd;
    assign unused_cmd  = ^{stride_i, strided_i};
    assign cmd_strided = 1'b0;
    assign cmd_stride  = '0;
`endif

    assign cmd_illegal = sew_e'(sew_i) == SEW_ILL || base_addr_i[1:0] != 2'b00 ||
                         (cmd_strided && (sew_e'(sew_i) != SEW32 || cmd_stride[1:0] != 2'b00));
    assign start     = state_q == IDLE && start_i;
    assign req       = state_q == ISSUE && req_cnt < nwords_q && 32'(outst_q) < MaxOutstanding && !err_q;
    // Responses with nothing outstanding are stale (e.g. issued before a reset) and dropped.
    assign rsp       = data_rvalid_i && outst_q != 2'd0;
    assign vrf_write = rsp && !is_store_q && !err_q && !data_err_i;

    vcve2_vlsu_addr_gen u_addr_gen (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (start),
        .inc_i     (req && data_gnt_i),
        .base_i    (base_q),
        .stride_i  (stride_q),
        .strided_i (strided_q),
        .nwords_i  (nwords_q),
        .last_be_i (last_be_q),
        .req_cnt_o (req_cnt),
        .addr_o    (addr),
        .be_o      (be)
    );

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        strided_d  = strided_q;
        base_d     = base_q;
        stride_d   = stride_q;
        nwords_d   = nwords_q;
        last_be_d  = last_be_q;
        vreg_d     = vreg_q;
        resp_cnt_d = resp_cnt_q + 8'(rsp);
        outst_d    = outst_q + 2'(req && data_gnt_i) - 2'(rsp);
        err_d      = err_q || (rsp && data_err_i);
        case (state_q)
            IDLE: if (start_i) begin
                is_store_d = is_store_i;
                strided_d  = cmd_strided;
                base_d     = base_addr_i;
                stride_d   = cmd_stride;
                nwords_d   = calc_nwords(vl_i, sew_e'(sew_i), cmd_strided);
                last_be_d  = cmd_strided ? 4'hF : calc_last_be(vl_i, sew_e'(sew_i));
                vreg_d     = vreg_base_i;
                resp_cnt_d = '0;
                err_d      = cmd_illegal;
                state_d    = cmd_illegal ? FIN : ISSUE;
            end
            ISSUE:   state_d = nwords_q == 8'd0 ? FIN : (req_cnt == nwords_q || err_q) ? DRAIN : ISSUE;
            DRAIN:   state_d = outst_d == 2'd0 ? FIN : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            strided_q  <= 1'b0;
            base_q     <= '0;
            stride_q   <= '0;
            nwords_q   <= '0;
            last_be_q  <= '0;
            vreg_q     <= '0;
            resp_cnt_q <= '0;
            outst_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            strided_q  <= strided_d;
            base_q     <= base_d;
            stride_q   <= stride_d;
            nwords_q   <= nwords_d;
            last_be_q  <= last_be_d;
            vreg_q     <= vreg_d;
            resp_cnt_q <= resp_cnt_d;
            outst_q    <= outst_d;
            err_q      <= err_d;
        end
    end

    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == FIN;
    assign err_o        = state_q == FIN && err_q;
    assign data_req_o   = req;
    assign data_we_o    = req && is_store_q;
    assign data_be_o    = req ? be : 4'h0;
    assign data_addr_o  = req ? addr : '0;
    assign data_wdata_o = (req && is_store_q) ? vrf_rdata_i : '0;
    assign vrf_raddr_o  = vreg_q + VrfAw'(req_cnt);
    assign vrf_we_o     = vrf_write;
    assign vrf_waddr_o  = vrf_write ? vreg_q + VrfAw'(resp_cnt_q) : '0;
    assign vrf_wdata_o  = vrf_write ? data_rdata_i : '0;
    assign vrf_wbe_o    = vrf_write ? word_be(resp_cnt_q, nwords_q, last_be_q) : 4'h0;

endmodule

// File: tb/tb_vcve2_vlsu_agu.sv
// tb_vcve2_vlsu_agu: directed table plus randomized commands against a transfer-level reference model.
module tb_vcve2_vlsu_agu;

    localparam int MAX_OUT = 2;
`ifdef VCVE2_VLSU_STRIDED_EN
    localparam bit STR_EN = 1'b1;
`else
    localparam bit STR_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        start = 0, is_store = 0, strided = 0;
    logic [31:0] base_addr = 0, stride = 0;
    logic [7:0]  vl = 0;
    logic [1:0]  sew = 0;
    logic [4:0]  vreg_base = 0;
    logic        busy, done, err;
    logic [4:0]  vrf_raddr, vrf_waddr;
    logic [31:0] vrf_rdata, vrf_wdata;
    logic        vrf_we;
    logic [3:0]  vrf_wbe;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt = 0, data_rvalid = 0, data_err = 0;
    logic [31:0] data_rdata = 0;

    always #5 clk = ~clk;

    vcve2_vlsu_agu #(.VrfAw(5), .MaxOutstanding(MAX_OUT)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .is_store_i(is_store),
        .base_addr_i(base_addr), .stride_i(stride), .vl_i(vl), .sew_i(sew),
        .strided_i(strided), .vreg_base_i(vreg_base), .busy_o(busy), .done_o(done),
        .err_o(err), .vrf_raddr_o(vrf_raddr), .vrf_rdata_i(vrf_rdata), .vrf_we_o(vrf_we),
        .vrf_waddr_o(vrf_waddr), .vrf_wdata_o(vrf_wdata), .vrf_wbe_o(vrf_wbe),
        .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
        .data_addr_o(data_addr), .data_wdata_o(data_wdata), .data_gnt_i(data_gnt),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err)
    );

    function automatic logic [31:0] vrf_f(input logic [4:0] a);
        return 32'hC0DE0000 ^ ({27'd0, a} * 32'h01010101);
    endfunction
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction
    assign vrf_rdata = vrf_f(vrf_raddr);

    int n_cmp = 0, n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic st; logic [31:0] base, stride; logic [7:0] vl; logic [1:0] sew; logic strided;
        logic [4:0] vreg; int gdly; int lag; int err_idx; int en; int ew; logic ee;
    } cmd_t;

    function automatic cmd_t mk(input logic st, input logic [31:0] base, input logic [31:0] stride,
                                input logic [7:0] vl, input logic [1:0] sew, input logic strided,
                                input logic [4:0] vreg, input int gdly, input int lag, input int err_idx,
                                input int en, input int ew, input logic ee);
        cmd_t c;
        c.st = st; c.base = base; c.stride = stride; c.vl = vl; c.sew = sew; c.strided = strided;
        c.vreg = vreg; c.gdly = gdly; c.lag = lag; c.err_idx = err_idx; c.en = en; c.ew = ew; c.ee = ee;
        return c;
    endfunction

    // Reference model: transfer-level arithmetic straight from the command semantics.
    function automatic bit m_str(input cmd_t c); return c.strided && STR_EN; endfunction
    function automatic bit m_illegal(input cmd_t c);
        return c.sew == 2'd3 || c.base[1:0] != 2'd0 || (m_str(c) && (c.sew != 2'd2 || c.stride[1:0] != 2'd0));
    endfunction
    function automatic int m_bytes(input cmd_t c); return int'(c.vl) * (1 << c.sew); endfunction
    function automatic int m_nwords(input cmd_t c);
        return m_str(c) ? int'(c.vl) : (m_bytes(c) + 3) / 4;
    endfunction
    function automatic logic [31:0] m_addr(input cmd_t c, input int i);
        return m_str(c) ? c.base + c.stride * 32'(i) : c.base + 32'(4 * i);
    endfunction
    function automatic logic [3:0] m_be(input cmd_t c, input int i);
        int left;
        left = m_bytes(c) - 4 * i;
        return (m_str(c) || left >= 4) ? 4'hF : 4'((1 << left) - 1);
    endfunction

    task automatic run_cmd(input cmd_t c, input string tag);
        logic [31:0] hs_addr[$], hs_wd[$], wr_d[$], pend_addr[$];
        logic [3:0]  hs_be[$], wr_be[$];
        logic        hs_we[$];
        logic [4:0]  wr_a[$];
        int pend_due[$], pend_idx[$];
        int cyc = 0, outst = 0, waitc = 0, cur_g, err_cyc = -1, late_hs = 0, max_out = 0, nw, exp_nwr, pend_at_done = -1;
        bit fin = 0, got_err = 0, stall = 0, ill, exp_e, err_seen = 0;
        logic [31:0] p_addr = 0, p_wd = 0;
        logic [3:0]  p_be = 0;
        nw  = m_nwords(c);
        ill = m_illegal(c);
        exp_e   = ill || (c.err_idx >= 0 && c.err_idx < nw);
        exp_nwr = ill ? 0 : c.st ? 0 : exp_e ? c.err_idx : nw;
        @(negedge clk);
        start = 1; is_store = c.st; base_addr = c.base; stride = c.stride; vl = c.vl;
        sew = c.sew; strided = c.strided; vreg_base = c.vreg;
        @(negedge clk);
        start = 0;
        cur_g = c.gdly < 0 ? int'($urandom_range(0, 2)) : c.gdly;
        while (!fin && cyc < 3000) begin
            data_rvalid = 0; data_err = 0; data_rdata = 0; data_gnt = 0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                data_rvalid = 1;
                data_rdata  = mem_f(pend_addr[0]);
                data_err    = pend_idx[0] == c.err_idx;
            end
            #1;
            data_gnt = data_req && waitc >= cur_g;
            #1;
            if (stall && !got_err) begin
                check({tag, " hold_req"}, data_req, 1);
                check({tag, " hold_addr"}, data_addr, p_addr);
                check({tag, " hold_be"}, data_be, p_be);
                check({tag, " hold_wdata"}, data_wdata, p_wd);
            end
            if (data_req && data_gnt) begin
                hs_addr.push_back(data_addr); hs_be.push_back(data_be);
                hs_we.push_back(data_we); hs_wd.push_back(data_wdata);
                if (got_err && cyc > err_cyc) late_hs++;
                pend_due.push_back(cyc + (c.lag < 0 ? int'($urandom_range(1, 3)) : c.lag));
                pend_addr.push_back(data_addr);
                pend_idx.push_back(hs_addr.size() - 1);
                outst++;
                if (outst > max_out) max_out = outst;
                waitc = 0;
                cur_g = c.gdly < 0 ? int'($urandom_range(0, 2)) : c.gdly;
            end else if (data_req) waitc++;
            stall = data_req && !data_gnt;
            p_addr = data_addr; p_be = data_be; p_wd = data_wdata;
            if (data_rvalid) begin
                if (data_err && !got_err) begin got_err = 1; err_cyc = cyc; end
                void'(pend_due.pop_front()); void'(pend_addr.pop_front()); void'(pend_idx.pop_front());
                outst--;
            end
            if (vrf_we) begin wr_a.push_back(vrf_waddr); wr_d.push_back(vrf_wdata); wr_be.push_back(vrf_wbe); end
            if (done) begin fin = 1; err_seen = err; pend_at_done = pend_due.size(); end
            else begin cyc++; @(negedge clk); end
        end
        data_rvalid = 0; data_err = 0; data_gnt = 0;
        if (!fin) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout: done not seen within 3000 cycles", tag);
            return;
        end
        check({tag, " err_o"}, err_seen, exp_e);
        check({tag, " drained"}, pend_at_done, 0);
        check({tag, " max_outst_ok"}, max_out <= MAX_OUT, 1);
        check({tag, " late_req"}, late_hs, 0);
        if (exp_e && !ill)
            check({tag, " nreq_range"}, hs_addr.size() >= c.err_idx + 1 && hs_addr.size() <= nw, 1);
        else
            check({tag, " nreq"}, hs_addr.size(), ill ? 0 : nw);
        for (int i = 0; i < hs_addr.size() && i < nw; i++) begin
            check($sformatf("%s addr[%0d]", tag, i), hs_addr[i], m_addr(c, i));
            check($sformatf("%s be[%0d]", tag, i), hs_be[i], m_be(c, i));
            check($sformatf("%s we[%0d]", tag, i), hs_we[i], c.st);
            check($sformatf("%s wdata[%0d]", tag, i), hs_wd[i], c.st ? vrf_f(5'(c.vreg + 5'(i))) : 0);
        end
        check({tag, " nwr"}, wr_a.size(), exp_nwr);
        for (int i = 0; i < wr_a.size() && i < exp_nwr; i++) begin
            check($sformatf("%s waddr[%0d]", tag, i), wr_a[i], 5'(c.vreg + 5'(i)));
            check($sformatf("%s vwdata[%0d]", tag, i), wr_d[i], mem_f(m_addr(c, i)));
            check($sformatf("%s wbe[%0d]", tag, i), wr_be[i], m_be(c, i));
        end
        if (c.en >= 0) begin
            check({tag, " tbl_nreq"}, hs_addr.size(), c.en);
            check({tag, " tbl_nwr"}, wr_a.size(), c.ew);
            check({tag, " tbl_err"}, err_seen, c.ee);
        end
        @(negedge clk); #2;
        check({tag, " done_pulse"}, done, 0);
        check({tag, " idle"}, busy, 0);
    endtask

    cmd_t tbl[11];
    cmd_t rc;

    initial begin
        tbl[0]  = mk(0, 32'h100, 0, 6, 2'd0, 0, 5'd3, 0, 1, -1, 2, 2, 0);
        tbl[1]  = mk(1, 32'h2000, 0, 3, 2'd2, 0, 5'd10, 2, 1, -1, 3, 0, 0);
        tbl[2]  = mk(0, 32'h4000, 0, 8, 2'd2, 0, 5'd20, 0, 3, -1, 8, 8, 0);
        tbl[3]  = mk(0, 32'h800, 0, 4, 2'd2, 0, 5'd1, 2, 1, 1, 2, 1, 1);
        tbl[4]  = mk(0, 32'h102, 0, 4, 2'd0, 0, 5'd0, 0, 1, -1, 0, 0, 1);
        tbl[5]  = mk(0, 32'h100, 0, 0, 2'd0, 0, 5'd0, 0, 1, -1, 0, 0, 0);
        tbl[6]  = mk(0, 32'hFFFFFFF8, 0, 5, 2'd1, 0, 5'd30, 1, 2, -1, 3, 3, 0);
        tbl[7]  = mk(1, 32'h40, 0, 2, 2'd3, 0, 5'd0, 0, 1, -1, 0, 0, 1);
        tbl[8]  = mk(0, 32'hFFFFFFF8, 8, 3, 2'd2, 1, 5'd5, 0, 1, -1, 3, 3, 0);
        tbl[9]  = mk(0, 32'h200, 8, 4, 2'd0, 1, 5'd0, 0, 1, -1, STR_EN ? 0 : 1, STR_EN ? 0 : 1, STR_EN);
        tbl[10] = mk(1, 32'h300, 0, 5, 2'd0, 0, 5'd7, 1, 2, -1, 2, 0, 0);

        repeat (2) @(negedge clk);
        #2;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst req", data_req, 0);
        check("rst vrf_we", vrf_we, 0);
        rst_ni = 1;

        for (int i = 0; i < 11; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a load with two requests in flight.
        @(negedge clk);
        start = 1; is_store = 0; base_addr = 32'h4000; vl = 8; sew = 2'd2; strided = 0; vreg_base = 5'd4;
        @(negedge clk);
        start = 0; data_gnt = 1;
        #2 check("rst_seq req0", data_req, 1);
        @(negedge clk); #2 check("rst_seq req1", data_req, 1);
        @(negedge clk); #2 check("rst_seq outst_full", data_req, 0);
        check("rst_seq busy", busy, 1);
        data_rvalid = 1; data_rdata = 32'hDEADBEEF; rst_ni = 0;
        #1;
        check("rst_mid req", data_req, 0);
        check("rst_mid we", data_we, 0);
        check("rst_mid be", data_be, 0);
        check("rst_mid addr", data_addr, 0);
        check("rst_mid wdata", data_wdata, 0);
        check("rst_mid raddr", vrf_raddr, 0);
        check("rst_mid vrf_we", vrf_we, 0);
        check("rst_mid waddr", vrf_waddr, 0);
        check("rst_mid vwdata", vrf_wdata, 0);
        check("rst_mid wbe", vrf_wbe, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        check("rst_mid err", err, 0);
        @(negedge clk); rst_ni = 1; #2;
        check("late_rvalid0 vrf_we", vrf_we, 0);
        @(negedge clk); #2;
        check("late_rvalid1 vrf_we", vrf_we, 0);
        check("late_rvalid busy", busy, 0);
        data_rvalid = 0; data_gnt = 0;

        for (int k = 0; k < 40; k++) begin
            logic [31:0] r;
            int nw;
            r = $urandom;
            rc.st = r[0];
            rc.strided = r[1];
            rc.sew = (r[7:4] == 4'd0) ? 2'd3 : (rc.strided && r[3:2] != 2'd0) ? 2'd2 : 2'(r[9:8] % 2'd3);
            rc.base = $urandom & ~32'h3;
            if (r[13:10] == 4'd0) rc.base[1:0] = 2'(1 + (r[15:14] % 2'd3));
            rc.stride = 32'($urandom_range(0, 64)) << 2;
            if (r[19:16] == 4'd0) rc.stride[1:0] = 2'd2;
            rc.vl = 8'($urandom_range(0, 20));
            rc.vreg = 5'($urandom_range(0, 31));
            rc.gdly = -1; rc.lag = -1; rc.en = -1; rc.ew = -1; rc.ee = 0;
            nw = m_nwords(rc);
            rc.err_idx = (r[22:20] == 3'd0 && nw > 0) ? int'($urandom_range(0, nw - 1)) : -1;
            run_cmd(rc, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
